uart_trans: RTL and testbench
=============================

Name: uart_trans

Overview:
- 8N1 UART transmitter: serialises one byte per frame onto `serial_out`.
- Frame format: start bit 0, eight data bits LSB first, stop bit 1. No parity.
- Bit period is `CLKS_PER_BIT` clocks; the default gives 9600 baud at 100 MHz.
- Sits between the byte-producing logic and the board TX pin; `done` tells the producer the frame has finished.

Parameters:
- `CLKS_PER_BIT`, default 10417: clocks per bit period. Legal values are 2 or more.

Ports:
- `clk`, input, 1: system clock. All logic is rising-edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `data_to_send`, input, 8: byte to transmit. Sampled only on frame start.
- `enable`, input, 1: level-sensitive transmit request.
- `serial_out`, output, 1: registered TX line. Idles high.
- `done`, output, 1: one-clock pulse when a frame finishes.
- `busy`, output, 1: high while a frame is in progress.

Behaviour:
- Reset (`rst_n`=0, asynchronous):
  - state=IDLE; bit counter, clock counter and shift register cleared.
  - `serial_out`=1, `done`=0, `busy`=0.
- Reset mid-frame aborts immediately: line returns high and no `done` pulse is issued.
- States: IDLE → START → DATA → STOP → CLEANUP → IDLE.
- IDLE:
  - `serial_out`=1, `busy`=0.
  - On a rising edge with `enable`=1: latch `data_to_send` into the shift register, clear the clock counter, go to START.
- START:
  - `serial_out`=0 for exactly `CLKS_PER_BIT` clocks, then go to DATA with bit index 0.
- DATA:
  - `serial_out`=bit[index] of the latched byte, held `CLKS_PER_BIT` clocks per bit.
  - After index 7 completes, go to STOP.
- STOP:
  - `serial_out`=1 for `CLKS_PER_BIT` clocks, then go to CLEANUP.
- CLEANUP:
  - `done`=1 for exactly this one clock; `serial_out`=1.
  - `enable` is ignored in this clock.
  - Next state is IDLE.
- Timing:
  - Start bit appears on `serial_out` in the first clock after the edge that samples `enable`=1.
  - Frame occupies 10×`CLKS_PER_BIT` clocks of line time.
  - `done` is high in clock 10×`CLKS_PER_BIT`+1 after the start edge.
- `busy`=1 in START, DATA, STOP and CLEANUP.
- `enable` and `data_to_send` changes during a frame have no effect; the byte latched at start is transmitted unaltered.
- Back-to-back: if `enable` is still 1 in IDLE after CLEANUP, a new frame starts at that edge. The gap between stop bit and next start bit is therefore 2 clocks of idle-high.
- Clock counter:
  - Width `$clog2(CLKS_PER_BIT)`.
  - Counts 0..`CLKS_PER_BIT`−1 and resets to 0 at each bit boundary.
  - No wrap beyond the terminal count.
- `done` is never asserted outside CLEANUP.

Test Plan:
- Reset: hold `rst_n`=0 with `enable`=1 → `serial_out`=1, `done`=0, `busy`=0 throughout. Release `rst_n`: a frame starts on the next edge.
- Single frame, `data_to_send`=8'h61, `enable` high for one bit period then low:
  - Line sequence, each bit 10417 clocks: 0,1,0,0,0,0,1,1,0,1.
  - `done` pulses for exactly 1 clock, then the line stays 1.
- Data stability: change `data_to_send` to 8'hFF mid-frame after starting with 8'h61 → transmitted bits still match 8'h61.
- Held enable: `enable` tied high with 8'hA5 → consecutive identical frames separated by exactly 2 idle-high clocks; one `done` pulse per frame.
- Mid-frame reset: assert `rst_n`=0 during data bit 3 → `serial_out`=1 immediately; no `done` pulse; after release with `enable`=0 the line remains idle.
- Small parameter, `CLKS_PER_BIT`=4, byte 8'h00 → start bit plus 8 data bits all 0 for 36 clocks total, stop bit 1 for 4 clocks, `done` on clock 41.

Source files
------------

// File: rtl/uart_trans.sv
// uart_trans: 8N1 UART transmitter, serialises one latched byte per frame onto serial_out
module uart_trans #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_to_send,
  input  logic       enable,
  output logic       serial_out,
  output logic       done,
  output logic       busy
);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] STOP    = 3'd3;
  localparam logic [2:0] CLEANUP = 3'd4;
  logic [2:0]    r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_serial;
  logic          r_done;
  logic          r_busy;
  logic          w_bit_end;
  assign w_bit_end  = r_clk_cnt == LAST;
  assign serial_out = r_serial;
  assign done       = r_done;
  assign busy       = r_busy;
  // Frame sequencer: line, done and busy are registered from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_serial  <= 1'b1;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done    <= 1'b0;
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          if (enable) begin
            r_shift  <= data_to_send;
            r_state  <= START;
            r_serial <= 1'b0;
            r_busy   <= 1'b1;
          end else begin
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        START: begin
          r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
          if (w_bit_end) begin
            r_state   <= DATA;
            r_bit_idx <= '0;
            r_serial  <= r_shift[0];
          end
        end
        DATA: begin
          r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
              r_state  <= STOP;
              r_serial <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_serial  <= r_shift[r_bit_idx + 3'd1];
            end
          end
        end
        STOP: begin
          r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
          if (w_bit_end) begin
            r_state <= CLEANUP;
            r_done  <= 1'b1;
          end
        end
        CLEANUP: begin
          r_state  <= IDLE;
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_serial <= 1'b1;
        end
        default: begin
          r_state  <= IDLE;
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_serial <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_trans.sv
// tb_uart_trans: table-driven and randomized frame checks against a per-cycle line model
module tb_uart_trans;
  localparam int C  = 4;
  localparam int FL = 10 * C;
  typedef struct {
    logic [7:0] d;
    logic [9:0] f;
    logic       chg;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] data_to_send = 8'h00;
  logic       serial_out;
  logic       done;
  logic       busy;
  int         n_cmp = 0;
  int         n_bad = 0;
  vec_t       tbl[5];

  uart_trans #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_to_send(data_to_send),
    .enable(enable),
    .serial_out(serial_out),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, t, act, exp);
    end
  endtask

  // frame as 10 line values, index 0 = start bit, 1..8 = data LSB first, 9 = stop bit
  function automatic logic [9:0] model(input logic [7:0] d);
    return 10'(512 + 2 * int'(d));
  endfunction

  // called at the negedge of cycle 1 of a frame; ends at the negedge of the second idle clock
  task automatic watch(input logic [9:0] f, input int drop_at, input int chg_at, input string nm);
    for (int t = 1; t <= FL + 2; t++) begin
      chk({nm, ".line"}, t, 32'(serial_out), (t <= FL) ? 32'(f[(t - 1) / C]) : 32'd1);
      chk({nm, ".done"}, t, 32'(done), 32'(t == FL + 1));
      chk({nm, ".busy"}, t, 32'(busy), 32'(t <= FL + 1));
      if (t == drop_at) enable = 1'b0;
      if (t == chg_at) data_to_send = 8'hFF;
      if (t < FL + 2) @(negedge clk);
    end
  endtask

  task automatic start(input logic [7:0] d);
    data_to_send = d;
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{8'h61, 10'h2C2, 1'b0};
    tbl[1] = '{8'h61, 10'h2C2, 1'b1};
    tbl[2] = '{8'h00, 10'h200, 1'b0};
    tbl[3] = '{8'hFF, 10'h3FE, 1'b0};
    tbl[4] = '{8'hA5, 10'h34A, 1'b0};
    rst_n = 1'b0;
    enable = 1'b1;
    data_to_send = 8'h61;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("rst.line", i, 32'(serial_out), 32'd1);
      chk("rst.done", i, 32'(done), 32'd0);
      chk("rst.busy", i, 32'(busy), 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    @(negedge clk);
    watch(model(8'h61), C, 0, "rst_rel");
    foreach (tbl[i]) begin
      start(tbl[i].d);
      watch(tbl[i].f, C, tbl[i].chg ? 4 * C : 0, "tbl");
    end
    start(8'hA5);
    watch(model(8'hA5), 0, 0, "held0");
    @(negedge clk);
    watch(model(8'hA5), 0, 0, "held1");
    @(negedge clk);
    watch(model(8'hA5), 1, 0, "held2");
    for (int r = 0; r < 20; r++) begin
      logic [7:0] d;
      d = 8'($urandom);
      start(d);
      watch(model(d), int'($urandom_range(1, FL + 1)), int'($urandom_range(0, FL)), "rand");
    end
    start(8'h52);
    repeat (4 * C + 1) @(negedge clk);
    chk("mid.bit3", 0, 32'(serial_out), 32'd0);
    enable = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid.line", 0, 32'(serial_out), 32'd1);
    chk("mid.busy", 0, 32'(busy), 32'd0);
    chk("mid.done", 0, 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int t = 1; t <= 3 * FL; t++) begin
      @(negedge clk);
      chk("post.line", t, 32'(serial_out), 32'd1);
      chk("post.done", t, 32'(done), 32'd0);
      chk("post.busy", t, 32'(busy), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
